// File: rtl/pc_redirect_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_redirect_unit_if : fetch-side branch-resolution / PC bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface pc_redirect_unit_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 BRANCH_SELECT;
  logic [31:0]          TARGET_ADDRESS;
  logic                 STALL;
  logic                 IMEM_BUSY;
  logic [31:0]          PC;
  logic [31:0]          PC_PLUS4;
  logic                 FETCH_VALID;
  logic                 IF_ID_FLUSH;
  logic                 ID_EX_FLUSH;
  logic                 REDIRECT_PENDING;
  logic                 MISALIGNED;
  logic [CNT_WIDTH-1:0] REDIRECT_COUNT;

  // master = pipeline/memory side, slave = the redirect unit
  modport master (
    output BRANCH_SELECT, TARGET_ADDRESS, STALL, IMEM_BUSY,
    input  PC, PC_PLUS4, FETCH_VALID, IF_ID_FLUSH, ID_EX_FLUSH,
           REDIRECT_PENDING, MISALIGNED, REDIRECT_COUNT
  );

  modport slave (
    input  BRANCH_SELECT, TARGET_ADDRESS, STALL, IMEM_BUSY,
    output PC, PC_PLUS4, FETCH_VALID, IF_ID_FLUSH, ID_EX_FLUSH,
           REDIRECT_PENDING, MISALIGNED, REDIRECT_COUNT
  );
endinterface
`default_nettype wire

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_redirect_unit : PC owner; applies EX-stage redirects, tolerates slow IMEM
// Rev 1.0
// ---------------------------------------------------------------------------
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  pc_redirect_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          pend_q, pend_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [31:0] tgt_aligned;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        br;
  logic        busy;

  assign br          = bus.BRANCH_SELECT;
  assign busy        = bus.IMEM_BUSY;
  assign tgt_aligned = {bus.TARGET_ADDRESS[31:2], 2'b00};
  assign pc_plus4    = pc_q + 32'd4;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0000_0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    fetch_valid = 1'b0;

    case (state_q)
      ST_RUN: begin
        fetch_valid = !busy && !br;
        if (br) begin
          if (!busy) begin
            pc_d = tgt_aligned;
          end else begin
            pend_d  = tgt_aligned;
            state_d = ST_REDIRECT;
          end
        end else if (busy) begin
          state_d = ST_WAIT_MEM;
        end else if (!bus.STALL) begin
          pc_d = pc_plus4;
        end
      end

      ST_WAIT_MEM: begin
        fetch_valid = !busy && !br;
        if (br) begin
          pend_d = tgt_aligned;
          if (busy) begin
            state_d = ST_REDIRECT;
          end else begin
            pc_d    = tgt_aligned;
            state_d = ST_RUN;
          end
        end else if (!busy) begin
          state_d = ST_RUN;
          if (!bus.STALL) pc_d = pc_plus4;
        end
      end

      ST_REDIRECT: begin
        // Stale fetch is dropped; a newer branch replaces the pending target.
        if (br) pend_d = tgt_aligned;
        if (!busy) begin
          pc_d    = br ? tgt_aligned : pend_q;
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase

    if (br && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  assign bus.PC               = pc_q;
  assign bus.PC_PLUS4         = pc_plus4;
  assign bus.FETCH_VALID      = fetch_valid && !RESET;
  assign bus.IF_ID_FLUSH      = br && !RESET;
  assign bus.ID_EX_FLUSH      = br && !RESET;
  assign bus.REDIRECT_PENDING = (state_q == ST_REDIRECT) && !RESET;
  assign bus.MISALIGNED       = br && (bus.TARGET_ADDRESS[1:0] != 2'b00) && !RESET;
  assign bus.REDIRECT_COUNT   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_redirect_unit : directed bench, RESET_PC=0x100, CNT_WIDTH=2
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pc_redirect_unit;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  pc_redirect_unit_if #(.CNT_WIDTH(2)) bus ();

  pc_redirect_unit #(
    .RESET_PC  (32'h0000_0100),
    .CNT_WIDTH (2)
  ) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic b, input logic [31:0] t, input logic s, input logic m);
    bus.BRANCH_SELECT  = b;
    bus.TARGET_ADDRESS = t;
    bus.STALL          = s;
    bus.IMEM_BUSY      = m;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flush(input string tag, input logic exp);
    chk({tag, "_ifid"}, {31'd0, bus.IF_ID_FLUSH}, {31'd0, exp});
    chk({tag, "_idex"}, {31'd0, bus.ID_EX_FLUSH}, {31'd0, exp});
  endtask

  initial begin
    RESET = 1'b1;
    drive(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_pc", bus.PC, 32'h100);
    chk("rst_fv", {31'd0, bus.FETCH_VALID}, 32'd0);
    chk_flush("rst_flush", 1'b0);
    chk("rst_mis", {31'd0, bus.MISALIGNED}, 32'd0);
    chk("rst_pend", {31'd0, bus.REDIRECT_PENDING}, 32'd0);
    chk("rst_cnt", {30'd0, bus.REDIRECT_COUNT}, 32'd0);

    RESET = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("run_pc0", bus.PC, 32'h100);
    chk("run_p4", bus.PC_PLUS4, 32'h104);
    chk("run_fv", {31'd0, bus.FETCH_VALID}, 32'd1);
    chk_flush("run_flush", 1'b0);
    tick(); chk("run_pc1", bus.PC, 32'h104);
    tick(); chk("run_pc2", bus.PC, 32'h108);
    tick(); chk("run_pc3", bus.PC, 32'h10C);

    // busy for 3 cycles, branch to 0x300 in the 2nd
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("busy1_fv", {31'd0, bus.FETCH_VALID}, 32'd0);
    tick();
    chk("busy1_pc", bus.PC, 32'h10C);
    chk("busy1_pend", {31'd0, bus.REDIRECT_PENDING}, 32'd0);
    drive(1'b1, 32'h300, 1'b0, 1'b1);
    chk_flush("busy2_flush", 1'b1);
    tick();
    chk("busy2_pc", bus.PC, 32'h10C);
    chk("busy2_cnt", {30'd0, bus.REDIRECT_COUNT}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("busy3_pend", {31'd0, bus.REDIRECT_PENDING}, 32'd1);
    chk("busy3_fv", {31'd0, bus.FETCH_VALID}, 32'd0);
    tick();
    chk("disc_pc", bus.PC, 32'h10C);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("disc_fv", {31'd0, bus.FETCH_VALID}, 32'd0);
    chk("disc_pend", {31'd0, bus.REDIRECT_PENDING}, 32'd1);
    tick();
    chk("redir_pc", bus.PC, 32'h300);
    chk("redir_pend", {31'd0, bus.REDIRECT_PENDING}, 32'd0);

    // plain redirect in RUN
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    chk_flush("br200_flush", 1'b1);
    chk("br200_fv", {31'd0, bus.FETCH_VALID}, 32'd0);
    tick();
    chk("br200_pc", bus.PC, 32'h200);
    chk("br200_cnt", {30'd0, bus.REDIRECT_COUNT}, 32'd2);

    // misaligned target
    drive(1'b1, 32'h207, 1'b0, 1'b0);
    chk("mis_pulse", {31'd0, bus.MISALIGNED}, 32'd1);
    tick();
    chk("mis_pc", bus.PC, 32'h204);
    chk("mis_cnt", {30'd0, bus.REDIRECT_COUNT}, 32'd3);

    // branch beats stall, then stall holds
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    chk("mis_clear", {31'd0, bus.MISALIGNED}, 32'd0);
    tick();
    chk("stbr_pc", bus.PC, 32'h40);
    chk("sat_cnt4", {30'd0, bus.REDIRECT_COUNT}, 32'd3);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("stall_fv", {31'd0, bus.FETCH_VALID}, 32'd1);
    tick(); chk("stall_pc1", bus.PC, 32'h40);
    tick(); chk("stall_pc2", bus.PC, 32'h40);

    // wrap
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    tick();
    chk("wrap_pc", bus.PC, 32'hFFFF_FFFC);
    chk("wrap_p4", bus.PC_PLUS4, 32'h0);
    chk("sat_cnt5", {30'd0, bus.REDIRECT_COUNT}, 32'd3);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("wrap_pc0", bus.PC, 32'h0);

    // WAIT_MEM exit with stall (no advance) and without (advance)
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick(); chk("wm_hold", bus.PC, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick(); chk("wm_stall", bus.PC, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick(); chk("wm_run", bus.PC, 32'h4);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick(); chk("wm2_hold", bus.PC, 32'h4);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick(); chk("wm2_adv", bus.PC, 32'h8);

    // reset while a redirect is pending
    drive(1'b1, 32'h500, 1'b0, 1'b1);
    tick();
    chk("rr_pend", {31'd0, bus.REDIRECT_PENDING}, 32'd1);
    chk("rr_pc", bus.PC, 32'h8);
    RESET = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("rr_pend_rst", {31'd0, bus.REDIRECT_PENDING}, 32'd0);
    tick();
    chk("rr_pc_rst", bus.PC, 32'h100);
    chk("rr_cnt_rst", {30'd0, bus.REDIRECT_COUNT}, 32'd0);
    RESET = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("rr_pend_after", {31'd0, bus.REDIRECT_PENDING}, 32'd0);
    tick();
    chk("rr_pc_after", bus.PC, 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
